// File: rtl/stepper_phase_decoder_pkg.sv
// Shared constants, state encoding and pattern decode for the stepper phase read-back.
package stepper_pkg;

  localparam logic [3:0] PH_IDX0 = 4'b0101;
  localparam logic [3:0] PH_IDX1 = 4'b0110;
  localparam logic [3:0] PH_IDX2 = 4'b1010;
  localparam logic [3:0] PH_IDX3 = 4'b1001;
  localparam logic [3:0] PH_IDLE = 4'b0000;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } dec_state_t;

  typedef struct packed {
    logic       valid;
    logic       idle;
    logic [1:0] idx;
  } pat_info_t;

  function automatic pat_info_t pattern_to_idx(input logic [3:0] pat);
    pat_info_t r;
    r = '0;
    case (pat)
      PH_IDX0: begin r.valid = 1'b1; r.idx = 2'd0; end
      PH_IDX1: begin r.valid = 1'b1; r.idx = 2'd1; end
      PH_IDX2: begin r.valid = 1'b1; r.idx = 2'd2; end
      PH_IDX3: begin r.valid = 1'b1; r.idx = 2'd3; end
      PH_IDLE: r.idle = 1'b1;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/stepper_phase_decoder_if.sv
// Coil-phase read-back bus: raw phase lines and clears in, decoded motion and status out.
interface stepper_phase_decoder_if #(
  parameter int POS_WIDTH = 16
);

  logic [3:0]                  phase_in;
  logic                        clear_pos;
  logic                        clear_err;
  logic                        step_valid;
  logic                        step_dir;
  logic signed [POS_WIDTH-1:0] position;
  logic [1:0]                  phase_idx;
  logic                        locked;
  logic                        err_illegal;
  logic                        err_skip;
  logic                        stalled;

  modport master (
    output phase_in, clear_pos, clear_err,
    input  step_valid, step_dir, position, phase_idx, locked,
           err_illegal, err_skip, stalled
  );

  modport slave (
    input  phase_in, clear_pos, clear_err,
    output step_valid, step_dir, position, phase_idx, locked,
           err_illegal, err_skip, stalled
  );

endinterface

// File: rtl/stepper_phase_decoder_phase_filter.sv
// Synchronizes the asynchronous coil lines and accepts a pattern only after it has
// been seen unchanged for STABLE_CYCLES samples; accept pulses once per change.
module phase_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] phase_in,
  output logic [3:0] pattern,
  output logic       accept
);

  localparam int CW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [3:0]    sync_q [SYNC_STAGES];
  logic [3:0]    sync_next;
  logic [3:0]    sync_out;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_nx;

  // Count runs on the value entering the last stage so the acceptance decision
  // lands on the same edge as the final stable sample reaches the sync output.
  assign sync_next = sync_q[SYNC_STAGES-2];
  assign sync_out  = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_nx = cnt_q;
    if (sync_next != sync_out) begin
      cnt_nx = CW'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_nx = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= 4'b0000;
      end
      cnt_q   <= '0;
      pattern <= 4'b0000;
      accept  <= 1'b0;
    end else begin
      sync_q[0] <= phase_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      cnt_q  <= cnt_nx;
      accept <= 1'b0;
      if ((cnt_nx == CNT_MAX) && (sync_next != pattern)) begin
        pattern <= sync_next;
        accept  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/stepper_phase_decoder.sv
// Full-step coil-phase read-back: decodes filtered phase changes into steps,
// tracks signed position, flags illegal/skipped patterns and detects stalls.
//
//  state    | meaning
//  UNLOCKED | no legal pattern accepted since reset, idle or illegal pattern
//  LOCKED   | tracking a legal pattern; transitions decode into steps
module stepper_phase_decoder
  import stepper_pkg::*;
#(
  parameter int POS_WIDTH      = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 20_000_000
) (
  input logic                      clk_100mhz,
  input logic                      rst,
  stepper_phase_decoder_if.slave   bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  logic [3:0]           flt_pattern;
  logic                 flt_accept;
  pat_info_t            info;
  logic [1:0]           delta;

  dec_state_t           state_q, state_nx;
  logic                 step_q, step_nx;
  logic                 dir_q, dir_nx;
  logic [1:0]           idx_q, idx_nx;
  logic [POS_WIDTH-1:0] pos_q, pos_nx;
  logic                 ill_q, ill_nx;
  logic                 skip_q, skip_nx;
  logic [TW-1:0]        timer_q, timer_nx;

  phase_filter #(
    .SYNC_STAGES   (SYNC_STAGES),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clk      (clk_100mhz),
    .rst      (rst),
    .phase_in (bus.phase_in),
    .pattern  (flt_pattern),
    .accept   (flt_accept)
  );

  assign info  = pattern_to_idx(flt_pattern);
  assign delta = info.idx - idx_q;

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      state_q <= UNLOCKED;
    end else begin
      state_q <= state_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    step_nx  = 1'b0;
    dir_nx   = dir_q;
    idx_nx   = idx_q;
    pos_nx   = pos_q;
    ill_nx   = ill_q & ~bus.clear_err;
    skip_nx  = skip_q & ~bus.clear_err;
    timer_nx = timer_q;

    if (flt_accept) begin
      case (state_q)
        UNLOCKED: begin
          if (info.valid) begin
            state_nx = LOCKED;
            idx_nx   = info.idx;
          end else if (!info.idle) begin
            ill_nx = 1'b1;
          end
        end
        LOCKED: begin
          if (info.valid) begin
            idx_nx = info.idx;
            case (delta)
              2'd1: begin
                step_nx = 1'b1;
                dir_nx  = 1'b1;
                pos_nx  = pos_q + POS_WIDTH'(1);
              end
              2'd3: begin
                step_nx = 1'b1;
                dir_nx  = 1'b0;
                pos_nx  = pos_q - POS_WIDTH'(1);
              end
              2'd2:    skip_nx = 1'b1;
              default: skip_nx = skip_nx;
            endcase
          end else begin
            state_nx = UNLOCKED;
            if (!info.idle) begin
              ill_nx = 1'b1;
            end
          end
        end
        default: state_nx = UNLOCKED;
      endcase
    end

    if (bus.clear_pos) begin
      pos_nx = '0;
    end

    // Timer restarts on lock entry and on every step; held at zero while unlocked.
    if ((state_nx != LOCKED) || (state_q != LOCKED) || step_nx) begin
      timer_nx = '0;
    end else if (timer_q != TMAX) begin
      timer_nx = timer_q + TW'(1);
    end
  end

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      idx_q   <= 2'd0;
      pos_q   <= '0;
      ill_q   <= 1'b0;
      skip_q  <= 1'b0;
      timer_q <= '0;
    end else begin
      step_q  <= step_nx;
      dir_q   <= dir_nx;
      idx_q   <= idx_nx;
      pos_q   <= pos_nx;
      ill_q   <= ill_nx;
      skip_q  <= skip_nx;
      timer_q <= timer_nx;
    end
  end

  assign bus.step_valid  = step_q;
  assign bus.step_dir    = dir_q;
  assign bus.position    = $signed(pos_q);
  assign bus.phase_idx   = idx_q;
  assign bus.locked      = (state_q == LOCKED);
  assign bus.err_illegal = ill_q;
  assign bus.err_skip    = skip_q;
  assign bus.stalled     = (state_q == LOCKED) && (timer_q == TMAX);

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Directed bench for stepper_phase_decoder; second instance with single-sample
// acceptance is used to reach the position wrap boundary quickly.
module tb_stepper_phase_decoder;

  logic clk_100mhz;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   pulses;
  int   base;
  logic [3:0] pats [4];

  stepper_phase_decoder_if #(.POS_WIDTH(16)) bus ();
  stepper_phase_decoder_if #(.POS_WIDTH(16)) bus2 ();

  stepper_phase_decoder #(
    .POS_WIDTH(16), .SYNC_STAGES(2), .STABLE_CYCLES(4), .TIMEOUT_CYCLES(1000)
  ) dut (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .bus        (bus.slave)
  );

  stepper_phase_decoder #(
    .POS_WIDTH(16), .SYNC_STAGES(2), .STABLE_CYCLES(1), .TIMEOUT_CYCLES(1000)
  ) dut_fast (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .bus        (bus2.slave)
  );

  initial clk_100mhz = 1'b0;
  always #5 clk_100mhz = ~clk_100mhz;

  initial pulses = 0;
  always @(negedge clk_100mhz) if (bus.step_valid) pulses = pulses + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic [3:0] p, input int n);
    bus.phase_in = p;
    repeat (n) @(negedge clk_100mhz);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    pats[0] = 4'b0101; pats[1] = 4'b0110; pats[2] = 4'b1010; pats[3] = 4'b1001;
    rst = 1'b1;
    bus.phase_in = 4'b0000; bus.clear_pos = 1'b0; bus.clear_err = 1'b0;
    bus2.phase_in = 4'b0000; bus2.clear_pos = 1'b0; bus2.clear_err = 1'b0;
    repeat (3) @(negedge clk_100mhz);
    check_val("rst_locked", {31'd0, bus.locked}, 32'd0);
    check_val("rst_pos", {16'd0, bus.position}, 32'd0);
    check_val("rst_step", {31'd0, bus.step_valid}, 32'd0);
    check_val("rst_errs", {30'd0, bus.err_illegal, bus.err_skip}, 32'd0);
    check_val("rst_stalled", {31'd0, bus.stalled}, 32'd0);
    rst = 1'b0;

    // forward sweep: first pattern locks, seven steps follow
    base = pulses;
    hold(4'b0000, 20);
    for (int k = 0; k < 8; k++) hold(pats[k % 4], 20);
    check_val("fwd_pulses", pulses - base, 32'd7);
    check_val("fwd_locked", {31'd0, bus.locked}, 32'd1);
    check_val("fwd_dir", {31'd0, bus.step_dir}, 32'd1);
    check_val("fwd_pos", {16'd0, bus.position}, 32'd7);
    check_val("fwd_idx", {30'd0, bus.phase_idx}, 32'd3);

    // to idx0, clear position, then reverse sweep
    hold(4'b0101, 20);
    check_val("fwd_pos8", {16'd0, bus.position}, 32'd8);
    bus.clear_pos = 1'b1;
    @(negedge clk_100mhz);
    bus.clear_pos = 1'b0;
    check_val("clr_pos", {16'd0, bus.position}, 32'd0);
    base = pulses;
    hold(4'b1001, 20); hold(4'b1010, 20); hold(4'b0110, 20); hold(4'b0101, 20);
    check_val("rev_pulses", pulses - base, 32'd4);
    check_val("rev_dir", {31'd0, bus.step_dir}, 32'd0);
    check_val("rev_pos", {16'd0, bus.position}, 32'h0000FFFC);

    // skip idx0 -> idx2, then a forward step
    base = pulses;
    hold(4'b1010, 20);
    check_val("skip_err", {31'd0, bus.err_skip}, 32'd1);
    check_val("skip_pos", {16'd0, bus.position}, 32'h0000FFFC);
    check_val("skip_idx", {30'd0, bus.phase_idx}, 32'd2);
    check_val("skip_locked", {31'd0, bus.locked}, 32'd1);
    check_val("skip_pulses", pulses - base, 32'd0);
    hold(4'b1001, 20);
    check_val("after_skip_pos", {16'd0, bus.position}, 32'h0000FFFD);
    check_val("after_skip_dir", {31'd0, bus.step_dir}, 32'd1);

    // illegal pattern drops lock; clear_err clears both sticky flags
    hold(4'b1111, 20);
    check_val("ill_err", {31'd0, bus.err_illegal}, 32'd1);
    check_val("ill_locked", {31'd0, bus.locked}, 32'd0);
    bus.clear_err = 1'b1;
    @(negedge clk_100mhz);
    bus.clear_err = 1'b0;
    check_val("clr_err", {30'd0, bus.err_illegal, bus.err_skip}, 32'd0);

    // relock without a step, then a 3-cycle glitch is ignored
    base = pulses;
    hold(4'b0101, 20);
    check_val("relock", {31'd0, bus.locked}, 32'd1);
    check_val("relock_pos", {16'd0, bus.position}, 32'h0000FFFD);
    hold(4'b0110, 3);
    hold(4'b0101, 20);
    check_val("glitch_pulses", pulses - base, 32'd0);

    // latency: step appears on the sixth edge after the change
    hold(4'b0110, 5);
    check_val("lat5_step", {31'd0, bus.step_valid}, 32'd0);
    hold(4'b0110, 1);
    check_val("lat6_step", {31'd0, bus.step_valid}, 32'd1);
    check_val("lat6_pos", {16'd0, bus.position}, 32'h0000FFFE);

    // stall after exactly 1000 cycles without a step
    hold(4'b0110, 999);
    check_val("stall_999", {31'd0, bus.stalled}, 32'd0);
    check_val("one_pulse", {31'd0, bus.step_valid}, 32'd0);
    hold(4'b0110, 1);
    check_val("stall_1000", {31'd0, bus.stalled}, 32'd1);
    hold(4'b1010, 6);
    check_val("unstall_step", {31'd0, bus.step_valid}, 32'd1);
    check_val("unstall", {31'd0, bus.stalled}, 32'd0);
    check_val("unstall_pos", {16'd0, bus.position}, 32'h0000FFFF);

    // asynchronous reset mid-run, then relock without a step
    hold(4'b1010, 3);
    rst = 1'b1;
    #1;
    check_val("arst_pos", {16'd0, bus.position}, 32'd0);
    check_val("arst_locked", {31'd0, bus.locked}, 32'd0);
    check_val("arst_misc", {28'd0, bus.step_dir, bus.phase_idx, bus.stalled}, 32'd0);
    @(negedge clk_100mhz);
    rst = 1'b0;
    base = pulses;
    hold(4'b1010, 20);
    check_val("post_rst_locked", {31'd0, bus.locked}, 32'd1);
    check_val("post_rst_pulses", pulses - base, 32'd0);
    check_val("post_rst_pos", {16'd0, bus.position}, 32'd0);
    check_val("post_rst_idx", {30'd0, bus.phase_idx}, 32'd2);

    // wrap 0x7FFF -> 0x8000 on the single-sample instance
    bus2.phase_in = 4'b0101;
    repeat (10) @(negedge clk_100mhz);
    for (int i = 1; i <= 32767; i++) begin
      bus2.phase_in = pats[i % 4];
      @(negedge clk_100mhz);
    end
    repeat (10) @(negedge clk_100mhz);
    check_val("wrap_pre", {16'd0, bus2.position}, 32'h00007FFF);
    bus2.phase_in = 4'b0101;
    repeat (10) @(negedge clk_100mhz);
    check_val("wrap_post", {16'd0, bus2.position}, 32'h00008000);
    check_val("wrap_dir", {31'd0, bus2.step_dir}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stepper_phase_decoder.md
# stepper_phase_decoder

Monitors the four coil-drive lines of a full-step stepper sequencer and reconstructs motion. It synchronizes and deglitches the phase pattern, then decodes each legal transition into a step pulse with direction. It keeps a signed position count and flags illegal patterns, skipped steps and stalls. It sits beside the motor driver as the read-back/verification end of the coil-phase interface.

## Interface
Parameters:
- POS_WIDTH, 16, width of signed position counter
- SYNC_STAGES, 2, synchronizer flops on phase_in (≥2)
- STABLE_CYCLES, 4, consecutive identical synchronized samples required to accept a pattern (≥1)
- TIMEOUT_CYCLES, 20_000_000, cycles without an accepted step before `stalled` (200 ms at 100 MHz)

Ports:
- clk_100mhz  in  1  system clock
- rst  in  1  reset; one clock, asynchronous, active-high
- phase_in  in  4  coil lines, [0]=q1 [1]=q2 [2]=q3 [3]=q4, asynchronous to clk
- clear_pos  in  1  synchronous: position ← 0
- clear_err  in  1  synchronous: clears sticky error flags
- step_valid  out  1  one-cycle pulse per decoded ±1 step
- step_dir  out  1  direction of last step, 1=forward
- position  out  POS_WIDTH  signed step count
- phase_idx  out  2  index of current accepted legal pattern
- locked  out  1  a legal pattern has been accepted since idle/error
- err_illegal  out  1  sticky: illegal pattern accepted
- err_skip  out  1  sticky: index jumped by 2
- stalled  out  1  locked, no step for TIMEOUT_CYCLES

## Operation
- Legal patterns (phase_in): idx0=4'b0101, idx1=4'b0110, idx2=4'b1010, idx3=4'b1001. Idle=4'b0000. Any other value is illegal.
- Forward = idx 0→1→2→3→0; reverse = opposite order.
- Filter: a candidate replaces the accepted pattern only after STABLE_CYCLES consecutive equal synchronized samples. Shorter glitches are discarded.
- FSM states UNLOCKED, LOCKED; reset state UNLOCKED.
- UNLOCKED + accepted legal pattern → LOCKED. phase_idx updates; no step and no position change.
- UNLOCKED + idle or illegal → stay UNLOCKED. Illegal also sets err_illegal.
- LOCKED, accepted legal pattern with Δ=(new−old) mod 4:
  - Δ=1: step_valid, step_dir=1, position+1.
  - Δ=3: step_valid, step_dir=0, position−1.
  - Δ=2: set err_skip. No step, no position change. phase_idx updates and the block stays LOCKED.
- LOCKED + accepted idle → UNLOCKED. No error.
- LOCKED + accepted illegal → UNLOCKED and set err_illegal.
- position wraps modulo 2^POS_WIDTH (two's complement); no saturation.
- clear_pos in the same cycle as a step: clear wins and position=0. step_valid/step_dir still reflect the step.
- clear_err in the same cycle as a new error: the error wins and the flag stays 1.
- Stall timer: runs while LOCKED. It resets to 0 on each step and on entry to LOCKED, and saturates.
  - `stalled`=1 when the timer reaches TIMEOUT_CYCLES.
  - `stalled` clears on the next step or on leaving LOCKED.

## Timing
- Reset (async assert, sync-safe deassert handled at top level) sets all outputs to 0, the FSM to UNLOCKED, synchronizer/filter state to 4'b0000, and the timer to 0.
- Latency: a phase_in change that is stable from clock edge N reaches the sync output at N+SYNC_STAGES and is accepted at N+SYNC_STAGES+STABLE_CYCLES−1. step_valid, position, phase_idx, locked and flags update at N+SYNC_STAGES+STABLE_CYCLES. Default total is 6 cycles.
- step_valid is high exactly one cycle per accepted transition.
- stalled rises TIMEOUT_CYCLES cycles after the last step or lock entry.

## Structure
- Package `stepper_pkg`:
  - pattern constants PH_IDX0..PH_IDX3, PH_IDLE
  - enum `dec_state_t` {UNLOCKED, LOCKED}
  - function `pattern_to_idx(logic [3:0]) → {valid, idle, idx[1:0]}`
- Sub-module `phase_filter`: holds the SYNC_STAGES synchronizer and the STABLE_CYCLES acceptance counter. Outputs the accepted pattern plus a one-cycle `accept` strobe on change.
- Top level contains the FSM, position counter, error flags and stall timer.
- Tests run with TIMEOUT_CYCLES overridden to 1000.

## Test plan
- Idle, then 0101,0110,1010,1001 ×2, each held 20 cycles → locked=1, 7 step_valid pulses, step_dir=1, position=7.
- Locked at idx0, then 1001,1010,0110,0101 → 4 pulses, step_dir=0, position=−4.
- idx0 → 1010 (skip) → err_skip=1, position unchanged, phase_idx=2. Then 1001 → +1 step.
- Illegal 1111 held 20 cycles while locked → err_illegal=1, locked=0. Then clear_err → 0.
- Glitch 0110 for 3 cycles (STABLE_CYCLES=4) → no step; 4-cycle hold → exactly one step at 6-cycle latency.
- Locked, no change for 1000 cycles → stalled=1. Next step → stalled=0. position at 0x7FFF + forward step → 0x8000.
- Assert rst mid-sequence → all outputs 0 immediately; first legal pattern after release relocks without a step.
